// File: rtl/lc3_mem_pkg.sv
// Shared memory-operation encodings and memory-access FSM state type.
// The execute-stage Mem_Control decoder produces mem_op with these codes.
package lc3_mem_pkg;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_LDR = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_STR = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_STI = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_WR   = 2'd3
  } mem_state_t;

  // Codes 6 and 7 are accepted but perform no memory access.
  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_STI;
  endfunction

  // Plain stores go straight to the write state; everything else reads first.
  function automatic logic op_is_direct_store(input logic [2:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_memaccess_fsm.sv
// LC-3 data-memory access sequencer: LD/LDR/ST/STR single access,
// LDI/STI via a pointer read, with per-state ack timeout.
// Moore machine: every output is a register or a decode of state.
module lc3_memaccess_fsm
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [15:0] addr_in,
  input  logic [15:0] M_Data,
  input  logic [15:0] D_Dout,
  input  logic        D_ack,
  output logic [15:0] D_Addr,
  output logic [15:0] D_Din,
  output logic        D_rd,
  output logic        D_wr,
  output logic [15:0] memout,
  output logic        busy,
  output logic        mem_done,
  output logic        mem_err
);

  // Counter value at which one more ack-less cycle means abort.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  mem_state_t  state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [2:0]  op_q;
  logic [15:0] addr_q, data_q, ptr_q;
  logic        accept, ld_mem, ld_ptr, done_nxt, err_nxt;

  // Next-state and datapath-enable decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ld_mem    = 1'b0;
    ld_ptr    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (op_is_reserved(mem_op))         done_nxt  = 1'b1;
          else if (op_is_direct_store(mem_op)) state_nxt = S_WR;
          else                                 state_nxt = S_RD1;
        end
      end
      S_RD1: begin
        if (D_ack) begin
          if (op_q == OP_LDI) begin
            ld_ptr    = 1'b1;
            state_nxt = S_RD2;
          end else if (op_q == OP_STI) begin
            ld_ptr    = 1'b1;
            state_nxt = S_WR;
          end else begin
            ld_mem    = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_RD2: begin
        if (D_ack) begin
          ld_mem    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        if (D_ack) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides the normal decode only when no ack arrived.
    if (state != S_IDLE && !D_ack && wait_cnt == WAIT_LAST) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
    // Counter restarts on any state change and only runs while waiting.
    if (state == S_IDLE || state_nxt != state) wait_cnt_nxt = 4'd0;
    else                                        wait_cnt_nxt = wait_cnt + 4'd1;
  end

  // State, wait counter and completion pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_done <= done_nxt;
      mem_err  <= err_nxt;
    end
  end

  // Request capture, pointer and load-result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= 3'd0;
      addr_q <= 16'd0;
      data_q <= 16'd0;
      ptr_q  <= 16'd0;
      memout <= 16'd0;
    end else begin
      if (accept) begin
        op_q   <= mem_op;
        addr_q <= addr_in;
        data_q <= M_Data;
      end
      if (ld_ptr) ptr_q  <= D_Dout;
      if (ld_mem) memout <= D_Dout;
    end
  end

  // Strobes and address decode straight from state and held registers.
  assign D_rd   = (state == S_RD1) || (state == S_RD2);
  assign D_wr   = (state == S_WR);
  assign D_Addr = ((state == S_RD2) || (state == S_WR && op_q == OP_STI)) ? ptr_q : addr_q;
  assign D_Din  = data_q;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_lc3_memaccess_fsm.sv
// Directed bench for lc3_memaccess_fsm: inputs change 1 time unit after
// the rising edge, outputs are sampled at that same point.
module tb_lc3_memaccess_fsm;
  import lc3_mem_pkg::*;

  logic        clock, reset, req_valid, D_ack;
  logic [2:0]  mem_op;
  logic [15:0] addr_in, M_Data, D_Dout, D_Addr, D_Din, memout;
  logic        D_rd, D_wr, busy, mem_done, mem_err;
  logic [15:0] m3000, m4000;
  int          n_chk, n_fail;

  lc3_memaccess_fsm #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .mem_op(mem_op),
    .addr_in(addr_in), .M_Data(M_Data), .D_Dout(D_Dout), .D_ack(D_ack),
    .D_Addr(D_Addr), .D_Din(D_Din), .D_rd(D_rd), .D_wr(D_wr),
    .memout(memout), .busy(busy), .mem_done(mem_done), .mem_err(mem_err)
  );

  // Tiny memory: two programmable words, everything else reads DEAD.
  assign D_Dout = (D_Addr == 16'h3000) ? m3000 :
                  (D_Addr == 16'h4000) ? m4000 : 16'hDEAD;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    mem_op    = op;
    addr_in   = a;
    M_Data    = d;
  endtask

  initial begin
    int  wr_cycles;
    bit  seen_done;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; mem_op = 3'd0; addr_in = 16'h0;
    M_Data = 16'h0; D_ack = 1'b0; m3000 = 16'h0; m4000 = 16'h0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {D_rd, D_wr}, 0);
    chk("rst_pulses", {mem_done, mem_err}, 0);
    chk("rst_memout", memout, 0);
    chk("rst_addr", D_Addr, 0);
    tick(); tick();
    reset = 1'b0;

    // LD 3000 -> BEEF, ack every cycle
    m3000 = 16'hBEEF; D_ack = 1'b1;
    req(OP_LD, 16'h3000, 16'h0);
    tick(); req_valid = 1'b0;
    chk("ld_rd", {D_rd, D_wr, busy}, 3'b101);
    chk("ld_addr", D_Addr, 16'h3000);
    chk("ld_nodone_early", mem_done, 0);
    tick();
    chk("ld_done", {mem_done, mem_err, busy, D_rd}, 4'b1000);
    chk("ld_memout", memout, 16'hBEEF);
    tick();
    chk("ld_done_pulse", mem_done, 0);

    // LDI 3000 -> 4000 -> 1234
    m3000 = 16'h4000; m4000 = 16'h1234;
    req(OP_LDI, 16'h3000, 16'h0);
    tick(); req_valid = 1'b0;
    chk("ldi_rd1", {D_rd, D_Addr}, {1'b1, 16'h3000});
    tick();
    chk("ldi_rd2", {D_rd, D_Addr}, {1'b1, 16'h4000});
    chk("ldi_nodone", mem_done, 0);
    tick();
    chk("ldi_done", {mem_done, D_rd}, 2'b10);
    chk("ldi_memout", memout, 16'h1234);

    // STI 3000 -> 5000, write A5A5
    m3000 = 16'h5000;
    req(OP_STI, 16'h3000, 16'hA5A5);
    tick(); req_valid = 1'b0;
    chk("sti_rd", {D_rd, D_wr, D_Addr}, {2'b10, 16'h3000});
    tick();
    chk("sti_wr", {D_rd, D_wr, D_Addr, D_Din}, {2'b01, 16'h5000, 16'hA5A5});
    tick();
    chk("sti_done", {mem_done, D_wr}, 2'b10);
    chk("sti_memout_kept", memout, 16'h1234);

    // ST with no ack: 15 write cycles then abort
    D_ack = 1'b0;
    req(OP_ST, 16'h2000, 16'h1111);
    tick(); req_valid = 1'b0;
    wr_cycles = 0; seen_done = 0;
    for (int i = 0; i < 40 && D_wr; i++) begin
      wr_cycles++;
      if (mem_done) seen_done = 1;
      if (i == 7) chk("st_to_hold", {D_Addr, D_Din}, {16'h2000, 16'h1111});
      tick();
    end
    chk("st_to_cycles", wr_cycles, 15);
    chk("st_to_err", {mem_err, mem_done, busy}, 3'b100);
    chk("st_to_nodone", seen_done, 0);
    chk("st_to_memout", memout, 16'h1234);
    tick();
    chk("st_to_err_pulse", mem_err, 0);

    // Reserved op: no strobe, done next cycle
    req(3'd6, 16'h3000, 16'h0);
    tick(); req_valid = 1'b0;
    chk("rsv", {busy, D_rd, D_wr, mem_done}, 4'b0001);
    chk("rsv_memout", memout, 16'h1234);
    tick();
    chk("rsv_pulse", mem_done, 0);

    // Ack while idle does nothing
    D_ack = 1'b1;
    tick();
    chk("idle_ack", {busy, mem_done, mem_err}, 0);
    D_ack = 1'b0;

    // LD, reset on the second wait cycle
    m3000 = 16'h7777;
    req(OP_LD, 16'h3000, 16'h0);
    tick(); req_valid = 1'b0;
    chk("rst_mid_wait1", D_rd, 1);
    tick();
    chk("rst_mid_wait2", D_rd, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_drop", {D_rd, busy, mem_done, mem_err}, 0);
    chk("rst_mid_memout", memout, 0);
    D_ack = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_after", {mem_done, mem_err, busy}, 0);

    // ST then LD held on req_valid: ignored while busy, accepted in done cycle
    m3000 = 16'hBEEF;
    req(OP_ST, 16'h2222, 16'h3333);
    tick();
    chk("b2b_st_wr", {D_wr, D_Addr, D_Din}, {1'b1, 16'h2222, 16'h3333});
    req(OP_LD, 16'h3000, 16'h0);
    tick();
    chk("b2b_st_done", {mem_done, busy, D_rd}, 3'b100);
    tick(); req_valid = 1'b0;
    chk("b2b_ld_rd", {D_rd, D_Addr, mem_done}, {1'b1, 16'h3000, 1'b0});
    tick();
    chk("b2b_ld_done", {mem_done, memout}, {1'b1, 16'hBEEF});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_fsm.md
LC3_MEMACCESS_FSM -- requirements
Module: lc3_memaccess_fsm

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles a data-memory access waits for D_ack before abort (range 1..15).
REQ-002 Clocking: one clock; reset is asynchronous and active-high (ports clock, reset).
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  execute stage presents a memory operation.
REQ-006 mem_op  in  3  operation: 0 LD, 1 LDR, 2 ST, 3 STR, 4 LDI, 5 STI; 6-7 reserved.
REQ-007 addr_in  in  16  effective address from execute (pcout or aluout).
REQ-008 M_Data  in  16  store data from execute.
REQ-009 D_Dout  in  16  data-memory read data, valid when D_ack=1.
REQ-010 D_ack  in  1  data memory completes current access at this edge.
REQ-011 D_Addr  out  16  data-memory address.
REQ-012 D_Din  out  16  data-memory write data.
REQ-013 D_rd  out  1  read strobe.
REQ-014 D_wr  out  1  write strobe.
REQ-015 memout  out  16  load result for writeback.
REQ-016 busy  out  1  high whenever state is not IDLE; upstream stalls.
REQ-017 mem_done  out  1  one-cycle pulse: operation complete.
REQ-018 mem_err  out  1  one-cycle pulse: timeout abort.

Function
REQ-019 States: IDLE, RD1, RD2, WR; all outputs driven from registers or decoded from state only (Moore, no input-to-output paths).
REQ-020 IDLE: req_valid=1 latches mem_op, addr_in, M_Data; next state RD1 for LD/LDR/LDI/STI, WR for ST/STR; req_valid while busy=1 ignored.
REQ-021 Reserved op accepted in IDLE: no strobe, stays IDLE, mem_done pulses next cycle, memout unchanged.
REQ-022 RD1: D_rd=1, D_Addr=latched addr; on D_ack: LD/LDR -> memout<=D_Dout, IDLE, mem_done; LDI -> ptr<=D_Dout, RD2; STI -> ptr<=D_Dout, WR.
REQ-023 RD2: D_rd=1, D_Addr=ptr; on D_ack memout<=D_Dout, IDLE, mem_done.
REQ-024 WR: D_wr=1, D_Din=latched data, D_Addr=ptr for STI else latched addr; on D_ack IDLE, mem_done.
REQ-025 D_rd and D_wr never both 1; both 0 in IDLE; D_Addr/D_Din hold value while waiting for ack.
REQ-026 Latency with D_ack=1 every cycle: LD/ST 2 cycles accept-edge to mem_done; LDI/STI 3.
REQ-027 4-bit wait counter clears on every state entry, increments each non-IDLE cycle without D_ack; reaching TIMEOUT -> IDLE, mem_err pulse, no mem_done, memout unchanged.
REQ-028 mem_done cycle is IDLE: a new req_valid in that cycle is accepted (back-to-back).
REQ-029 D_ack in IDLE ignored.

Reset
REQ-030 reset=1 forces immediately: state IDLE, counter 0, memout 0, ptr 0, latched op/addr/data 0, D_rd=D_wr=0, busy=mem_done=mem_err=0.
REQ-031 Reset mid-access drops strobes asynchronously; the aborted op produces neither mem_done nor mem_err.

Structure
REQ-032 Shared package lc3_mem_pkg holds mem_op encodings and the state enum; the execute-stage Mem_Control decoder uses the same encodings.
REQ-033 Single module; no sub-module needed.

Verification
REQ-034 LD addr_in=16'h3000, D_ack=1, D_Dout=16'hBEEF -> D_rd one cycle at 3000, mem_done 2 cycles after accept, memout=BEEF.
REQ-035 LDI addr 16'h3000, mem[3000]=16'h4000, mem[4000]=16'h1234 -> reads 3000 then 4000, memout=1234, mem_done 3 cycles after accept.
REQ-036 STI addr 16'h3000, mem[3000]=16'h5000, M_Data=16'hA5A5 -> read 3000, write A5A5 to 5000, D_wr one cycle.
REQ-037 ST with D_ack held 0, TIMEOUT=15 -> D_wr held 15 cycles, mem_err pulse, IDLE, no mem_done.
REQ-038 LD with D_ack delayed 3 cycles, reset asserted on 2nd wait cycle -> D_rd drops same cycle, memout=0, no mem_done; back-to-back ST then LD with D_ack=1 -> second accepted in first's mem_done cycle.
